// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage RV32I core. It captures decoded
// control and operand fields, inserts bubbles on load-use hazards or branch
// flushes, and raises the stall request that freezes the PC and IF/ID.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             flush,
    input  logic [7:0]       id_ctrl,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    output logic [7:0]       ex_ctrl,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Bit positions in the control byte {ALUSrc, MemtoReg, RegWrite, MemRead,
    // MemWrite, Branch, ALUOp1, ALUOp0}.
    localparam int unsigned CtrlAluSrc   = 7;
    localparam int unsigned CtrlMemRead  = 4;
    localparam int unsigned CtrlMemWrite = 3;

    logic uses_rs2;
    logic ex_is_load;
    logic rd_match;
    logic hazard;
    logic bubble;

    // Stores read rs2 as the store data even though ALUSrc selects the immediate.
    assign uses_rs2   = ~id_ctrl[CtrlAluSrc] | id_ctrl[CtrlMemWrite];
    assign ex_is_load = ex_valid & ex_ctrl[CtrlMemRead] & (ex_rd != 5'd0);
    assign rd_match   = (ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2));
    assign hazard     = ex_is_load & id_valid & rd_match;

    // A flushed ID instruction is never re-presented, so it must not stall.
    assign stall  = hazard & ~flush;
    assign bubble = flush | hazard;

    // Pipeline register: hold freezes, otherwise bubble or capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl     <= 8'h00;
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct3   <= 3'd0;
            ex_funct7b5 <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                // Only the fields that can trigger side effects are cleared.
                ex_ctrl  <= 8'h00;
                ex_valid <= 1'b0;
                ex_rd    <= 5'd0;
            end else begin
                ex_ctrl     <= id_valid ? id_ctrl : 8'h00;
                ex_valid    <= id_valid;
                ex_pc       <= id_pc;
                ex_rs1_data <= id_rs1_data;
                ex_rs2_data <= id_rs2_data;
                ex_imm      <= id_imm;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
                ex_funct3   <= id_funct3;
                ex_funct7b5 <= id_funct7b5;
            end
        end
    end

    // Saturating count of inserted bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!hold && bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage checked against a slot-level reference model.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             hold;
    logic             flush;
    logic [7:0]       id_ctrl;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [2:0]       id_funct3;
    logic             id_funct7b5;
    logic [7:0]       ex_ctrl;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_funct7b5;
    logic             stall;
    logic [CNT_W-1:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_ctrl(id_ctrl), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .stall(stall), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the EX slot.
    logic [7:0]      m_ctrl;
    logic            m_valid;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_pc, m_rs1_data, m_rs2_data, m_imm;
    logic [4:0]      m_rs1, m_rs2;
    logic [2:0]      m_funct3;
    logic            m_funct7b5;
    bit              m_known;   // data fields are defined (not left by a bubble)
    int              m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 8'h00; m_valid = 1'b0; m_rd = 5'd0;
        m_pc = '0; m_rs1_data = '0; m_rs2_data = '0; m_imm = '0;
        m_rs1 = 5'd0; m_rs2 = 5'd0; m_funct3 = 3'd0; m_funct7b5 = 1'b0;
        m_known = 1'b1; m_cnt = 0;
    endtask

    // A valid load in EX writing a nonzero register that the ID instruction reads.
    function automatic bit model_hazard();
        bit reads_rs2;
        bit ex_load;
        reads_rs2 = (id_ctrl[7] == 1'b0) || (id_ctrl[3] == 1'b1);
        ex_load   = m_valid && m_ctrl[4] && (m_rd != 0);
        return ex_load && id_valid &&
               ((id_rs1 == m_rd) || (reads_rs2 && (id_rs2 == m_rd)));
    endfunction

    task automatic model_edge();
        bit hz;
        hz = model_hazard();
        if (hold) return;
        if (flush || hz) begin
            m_ctrl = 8'h00; m_valid = 1'b0; m_rd = 5'd0; m_known = 1'b0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_ctrl = id_valid ? id_ctrl : 8'h00;
            m_valid = id_valid; m_rd = id_rd;
            m_pc = id_pc; m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data;
            m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2;
            m_funct3 = id_funct3; m_funct7b5 = id_funct7b5; m_known = 1'b1;
        end
    endtask

    task automatic randomize_id();
        id_ctrl     = 8'($urandom);
        id_valid    = ($urandom_range(0, 7) != 0);
        id_pc       = $urandom; id_rs1_data = $urandom;
        id_rs2_data = $urandom; id_imm      = $urandom;
        id_rs1      = 5'($urandom_range(0, 3));
        id_rs2      = 5'($urandom_range(0, 3));
        id_rd       = 5'($urandom_range(0, 3));
        id_funct3   = 3'($urandom); id_funct7b5 = 1'($urandom);
    endtask

    task automatic set_id(input logic [7:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] pc);
        randomize_id();
        id_ctrl = ctrl; id_valid = 1'b1;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_pc = pc;
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        #1;
        check_eq("stall", stall, (model_hazard() && !flush));
        @(posedge clk);
        model_edge();
        #1;
        check_eq("ex_valid", ex_valid, m_valid);
        check_eq("ex_ctrl", ex_ctrl, m_ctrl);
        check_eq("ex_rd", ex_rd, m_rd);
        check_eq("bubble_cnt", bubble_cnt, m_cnt);
        if (m_known) begin
            check_eq("ex_pc", ex_pc, m_pc);
            check_eq("ex_rs1_data", ex_rs1_data, m_rs1_data);
            check_eq("ex_rs2_data", ex_rs2_data, m_rs2_data);
            check_eq("ex_imm", ex_imm, m_imm);
            check_eq("ex_rs1", ex_rs1, m_rs1);
            check_eq("ex_rs2", ex_rs2, m_rs2);
            check_eq("ex_funct3", ex_funct3, m_funct3);
            check_eq("ex_funct7b5", ex_funct7b5, m_funct7b5);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, released at the next falling edge.
    task automatic do_reset();
        @(negedge clk);
        randomize_id();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_ex_ctrl", ex_ctrl, 8'h00);
        check_eq("rst_ex_valid", ex_valid, 1'b0);
        check_eq("rst_ex_rd", ex_rd, 5'd0);
        check_eq("rst_ex_pc", ex_pc, 32'd0);
        check_eq("rst_ex_imm", ex_imm, 32'd0);
        check_eq("rst_bubble_cnt", bubble_cnt, 16'd0);
        check_eq("rst_stall", stall, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] saved_pc;
    int          cnt0;

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        randomize_id();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pass-through of an R-type instruction.
        set_id(8'b00100010, 5'd1, 5'd2, 5'd5, 32'h40);
        step();
        check_eq("pt_ctrl", ex_ctrl, 8'h22);
        check_eq("pt_rd", ex_rd, 5'd5);
        check_eq("pt_pc", ex_pc, 32'h40);
        check_eq("pt_valid", ex_valid, 1'b1);

        // Load-use: lw x6 then add x?, x6.
        cnt0 = m_cnt;
        set_id(8'b11110000, 5'd1, 5'd3, 5'd6, 32'h44);
        step();
        set_id(8'b00100010, 5'd6, 5'd2, 5'd8, 32'h48);
        #1 check_eq("lu_stall_on", stall, 1'b1);
        step();
        check_eq("lu_bubble_valid", ex_valid, 1'b0);
        check_eq("lu_bubble_ctrl", ex_ctrl, 8'h00);
        #1 check_eq("lu_stall_off", stall, 1'b0);
        step();
        check_eq("lu_add_ctrl", ex_ctrl, 8'h22);
        check_eq("lu_add_pc", ex_pc, 32'h48);
        check_eq("lu_cnt", bubble_cnt, 16'(cnt0 + 1));

        // Load to x0 never stalls.
        set_id(8'b11110000, 5'd1, 5'd3, 5'd0, 32'h4c);
        step();
        set_id(8'b00100010, 5'd0, 5'd0, 5'd8, 32'h50);
        #1 check_eq("x0_stall", stall, 1'b0);
        step();

        // addi with x7 only in the rs2 field: no stall. sw with x7 as rs2: stall.
        set_id(8'b11110000, 5'd1, 5'd3, 5'd7, 32'h54);
        step();
        set_id(8'b10100000, 5'd1, 5'd7, 5'd9, 32'h58);
        #1 check_eq("addi_rs2_stall", stall, 1'b0);
        step();
        set_id(8'b11110000, 5'd1, 5'd3, 5'd7, 32'h5c);
        step();
        set_id(8'b10001000, 5'd1, 5'd7, 5'd0, 32'h60);
        #1 check_eq("sw_rs2_stall", stall, 1'b1);
        step();
        step();

        // Flush with a concurrent hazard.
        set_id(8'b11110000, 5'd1, 5'd3, 5'd6, 32'h64);
        step();
        cnt0 = m_cnt;
        set_id(8'b00100010, 5'd6, 5'd2, 5'd8, 32'h68);
        flush = 1'b1;
        #1 check_eq("flush_hz_stall", stall, 1'b0);
        step();
        flush = 1'b0;
        check_eq("flush_hz_valid", ex_valid, 1'b0);
        check_eq("flush_hz_cnt", bubble_cnt, 16'(cnt0 + 1));

        // Flush under hold for 3 cycles, bubble on the 4th edge.
        set_id(8'b00100010, 5'd1, 5'd2, 5'd5, 32'h70);
        step();
        saved_pc = 32'h70;
        hold = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            step();
            check_eq("hold_pc", ex_pc, saved_pc);
            check_eq("hold_valid", ex_valid, 1'b1);
        end
        hold = 1'b0;
        step();
        check_eq("hold_release_valid", ex_valid, 1'b0);
        flush = 1'b0;

        // Randomized traffic, with a mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            randomize_id();
            hold  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
        end

        // Saturation of the bubble counter.
        hold = 1'b0; flush = 1'b1;
        randomize_id();
        repeat (65540) @(posedge clk);
        #1;
        m_ctrl = 8'h00; m_valid = 1'b0; m_rd = 5'd0; m_known = 1'b0; m_cnt = 65535;
        check_eq("sat_cnt", bubble_cnt, 16'hffff);
        check_eq("sat_valid", ex_valid, 1'b0);
        @(negedge clk);
        step();
        flush = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
